// File: rtl/axi4_pkg.sv
// Shared AXI4 encodings and FSM state types for the slave memory.
package axi4_pkg;

    typedef enum logic [1:0] {
        FIXED = 2'd0,
        INCR  = 2'd1,
        WRAP  = 2'd2
    } burst_t;

    typedef enum logic [1:0] {
        OKAY   = 2'd0,
        SLVERR = 2'd2
    } resp_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wstate_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_FETCH,
        R_DATA
    } rstate_e;

endpackage

// File: rtl/axi4_slave_mem_ram.sv
// 1W1R synchronous RAM, 32-bit words with byte enables, 1-cycle read latency, read-first.
module axi4_slave_mem_ram #(
    parameter int unsigned AW = 10
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [3:0]    wstrb_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [2**AW];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb_i[b]) begin
                    mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
        rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/axi4_slave_mem.sv
// AXI4 slave memory: one outstanding write and one outstanding read, FIXED/INCR bursts.
module axi4_slave_mem
    import axi4_pkg::*;
#(
    parameter int unsigned MEM_AW  = 10,
    parameter logic [31:0] RST_VAL = 32'h0
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic [31:0] S_AXI_AWADDR,
    input  logic [7:0]  S_AXI_AWLEN,
    input  logic [1:0]  S_AXI_AWBURST,
    input  logic        S_AXI_AWVALID,
    output logic        S_AXI_AWREADY,
    input  logic [31:0] S_AXI_WDATA,
    input  logic [3:0]  S_AXI_WSTRB,
    input  logic        S_AXI_WLAST,
    input  logic        S_AXI_WVALID,
    output logic        S_AXI_WREADY,
    output logic [1:0]  S_AXI_BRESP,
    output logic        S_AXI_BVALID,
    input  logic        S_AXI_BREADY,
    input  logic [31:0] S_AXI_ARADDR,
    input  logic [7:0]  S_AXI_ARLEN,
    input  logic [1:0]  S_AXI_ARBURST,
    input  logic        S_AXI_ARVALID,
    output logic        S_AXI_ARREADY,
    output logic [31:0] S_AXI_RDATA,
    output logic [1:0]  S_AXI_RRESP,
    output logic        S_AXI_RLAST,
    output logic        S_AXI_RVALID,
    input  logic        S_AXI_RREADY
);

    wstate_e           w_state_q, w_state_d;
    logic [MEM_AW-1:0] waddr_q, waddr_d;
    logic [7:0]        wlen_q, wlen_d;
    logic              wfixed_q, wfixed_d;
    logic [8:0]        wcnt_q, wcnt_d;
    resp_t             bresp_q, bresp_d;

    rstate_e           r_state_q, r_state_d;
    logic [MEM_AW-1:0] raddr_q, raddr_d;
    logic [7:0]        rlen_q, rlen_d;
    logic              rfixed_q, rfixed_d;
    logic [7:0]        rcnt_q, rcnt_d;
    logic              rvalid_q, rvalid_d;
    logic              rlast_q, rlast_d;
    logic [31:0]       rdata_q, rdata_d;

    // Holds both address channels off until the first edge after reset release.
    logic              init_q;
    logic              ram_we;
    logic [31:0]       ram_rdata;
    logic              unused_addr;

    assign unused_addr = ^{S_AXI_AWADDR[31:MEM_AW+2], S_AXI_AWADDR[1:0],
                           S_AXI_ARADDR[31:MEM_AW+2], S_AXI_ARADDR[1:0]};

    assign S_AXI_AWREADY = init_q && (w_state_q == W_IDLE);
    assign S_AXI_WREADY  = (w_state_q == W_DATA);
    assign S_AXI_BVALID  = (w_state_q == W_RESP);
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = init_q && (r_state_q == R_IDLE);
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RLAST   = rlast_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = OKAY;

    always_comb begin
        w_state_d = w_state_q;
        waddr_d   = waddr_q;
        wlen_d    = wlen_q;
        wfixed_d  = wfixed_q;
        wcnt_d    = wcnt_q;
        bresp_d   = bresp_q;
        ram_we    = 1'b0;
        unique case (w_state_q)
            W_IDLE: begin
                if (S_AXI_AWVALID && init_q) begin
                    waddr_d   = S_AXI_AWADDR[MEM_AW+1:2];
                    wlen_d    = S_AXI_AWLEN;
                    wfixed_d  = (S_AXI_AWBURST == FIXED);
                    wcnt_d    = 9'd0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (S_AXI_WVALID) begin
                    // Beats beyond AWLEN are swallowed; the count mismatch flags SLVERR.
                    ram_we = (wcnt_q <= {1'b0, wlen_q});
                    if (!wfixed_q) waddr_d = waddr_q + MEM_AW'(1);
                    if (wcnt_q != '1) wcnt_d = wcnt_q + 9'd1;
                    if (S_AXI_WLAST) begin
                        bresp_d   = (wcnt_q != {1'b0, wlen_q}) ? SLVERR : OKAY;
                        w_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (S_AXI_BREADY) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        raddr_d   = raddr_q;
        rlen_d    = rlen_q;
        rfixed_d  = rfixed_q;
        rcnt_d    = rcnt_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rdata_d   = rdata_q;
        unique case (r_state_q)
            R_IDLE: begin
                if (S_AXI_ARVALID && init_q) begin
                    raddr_d   = S_AXI_ARADDR[MEM_AW+1:2];
                    rlen_d    = S_AXI_ARLEN;
                    rfixed_d  = (S_AXI_ARBURST == FIXED);
                    rcnt_d    = 8'd0;
                    r_state_d = R_FETCH;
                end
            end
            R_FETCH: r_state_d = R_DATA;
            R_DATA: begin
                if (!rvalid_q) begin
                    rvalid_d = 1'b1;
                    rdata_d  = ram_rdata;
                    rlast_d  = (rcnt_q == rlen_q);
                end else if (S_AXI_RREADY) begin
                    rvalid_d = 1'b0;
                    rlast_d  = 1'b0;
                    if (rlast_q) begin
                        r_state_d = R_IDLE;
                    end else begin
                        if (!rfixed_q) raddr_d = raddr_q + MEM_AW'(1);
                        rcnt_d    = rcnt_q + 8'd1;
                        r_state_d = R_FETCH;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            init_q    <= 1'b0;
            w_state_q <= W_IDLE;
            waddr_q   <= '0;
            wlen_q    <= '0;
            wfixed_q  <= 1'b0;
            wcnt_q    <= '0;
            bresp_q   <= OKAY;
            r_state_q <= R_IDLE;
            raddr_q   <= '0;
            rlen_q    <= '0;
            rfixed_q  <= 1'b0;
            rcnt_q    <= '0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rdata_q   <= RST_VAL;
        end else begin
            init_q    <= 1'b1;
            w_state_q <= w_state_d;
            waddr_q   <= waddr_d;
            wlen_q    <= wlen_d;
            wfixed_q  <= wfixed_d;
            wcnt_q    <= wcnt_d;
            bresp_q   <= bresp_d;
            r_state_q <= r_state_d;
            raddr_q   <= raddr_d;
            rlen_q    <= rlen_d;
            rfixed_q  <= rfixed_d;
            rcnt_q    <= rcnt_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rdata_q   <= rdata_d;
        end
    end

    axi4_slave_mem_ram #(
        .AW(MEM_AW)
    ) u_ram (
        .clk_i   (ACLK),
        .we_i    (ram_we),
        .waddr_i (waddr_q),
        .wdata_i (S_AXI_WDATA),
        .wstrb_i (S_AXI_WSTRB),
        .raddr_i (raddr_q),
        .rdata_o (ram_rdata)
    );

endmodule

// File: tb/tb_axi4_slave_mem.sv
// Directed self-checking bench for axi4_slave_mem.
module tb_axi4_slave_mem;

    localparam int TMO = 100;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b1;
    logic [31:0] S_AXI_AWADDR;
    logic [7:0]  S_AXI_AWLEN;
    logic [1:0]  S_AXI_AWBURST;
    logic        S_AXI_AWVALID;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WLAST;
    logic        S_AXI_WVALID;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY;
    logic [31:0] S_AXI_ARADDR;
    logic [7:0]  S_AXI_ARLEN;
    logic [1:0]  S_AXI_ARBURST;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RLAST;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;

    int checks = 0;
    int failures = 0;

    logic [31:0] wbuf [8];
    logic [31:0] rbuf [8];
    logic        rlbuf [8];
    logic [1:0]  rrbuf [8];
    int          rlat;

    always #5 ACLK = ~ACLK;

    axi4_slave_mem #(
        .MEM_AW (10),
        .RST_VAL(32'h0)
    ) dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWLEN   (S_AXI_AWLEN),
        .S_AXI_AWBURST (S_AXI_AWBURST),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WLAST   (S_AXI_WLAST),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARLEN   (S_AXI_ARLEN),
        .S_AXI_ARBURST (S_AXI_ARBURST),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RLAST   (S_AXI_RLAST),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        checks++;
        failures++;
        $error("FAIL %s observed=timeout expected=handshake", tag);
    endtask

    // Issues one write burst; WLAST goes with beat nbeats-1, BREADY held low for bhold cycles.
    task automatic axi_write(input logic [31:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input int nbeats, input logic [3:0] strb,
                             input int bhold, input logic [1:0] exp_resp);
        int t;
        S_AXI_AWADDR  = addr;
        S_AXI_AWLEN   = len;
        S_AXI_AWBURST = burst;
        S_AXI_AWVALID = 1'b1;
        t = 0;
        while (!S_AXI_AWREADY && t < TMO) begin @(posedge ACLK); #1; t++; end
        if (t >= TMO) timeout("aw_handshake");
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            S_AXI_WDATA  = wbuf[i];
            S_AXI_WSTRB  = strb;
            S_AXI_WLAST  = (i == nbeats - 1);
            S_AXI_WVALID = 1'b1;
            t = 0;
            while (!S_AXI_WREADY && t < TMO) begin @(posedge ACLK); #1; t++; end
            if (t >= TMO) timeout("w_handshake");
            @(posedge ACLK); #1;
        end
        S_AXI_WVALID = 1'b0;
        S_AXI_WLAST  = 1'b0;
        t = 0;
        while (!S_AXI_BVALID && t < TMO) begin @(posedge ACLK); #1; t++; end
        if (t >= TMO) timeout("b_valid");
        chk("bresp", {30'd0, S_AXI_BRESP}, {30'd0, exp_resp});
        for (int k = 0; k < bhold; k++) begin
            @(posedge ACLK); #1;
            chk("bvalid_hold", {31'd0, S_AXI_BVALID}, 32'd1);
            chk("bresp_hold", {30'd0, S_AXI_BRESP}, {30'd0, exp_resp});
            chk("awready_hold", {31'd0, S_AXI_AWREADY}, 32'd0);
        end
        S_AXI_BREADY = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_BREADY = 1'b0;
        chk("bvalid_drop", {31'd0, S_AXI_BVALID}, 32'd0);
        chk("awready_back", {31'd0, S_AXI_AWREADY}, 32'd1);
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst);
        int t;
        S_AXI_ARADDR  = addr;
        S_AXI_ARLEN   = len;
        S_AXI_ARBURST = burst;
        S_AXI_ARVALID = 1'b1;
        S_AXI_RREADY  = 1'b1;
        t = 0;
        while (!S_AXI_ARREADY && t < TMO) begin @(posedge ACLK); #1; t++; end
        if (t >= TMO) timeout("ar_handshake");
        @(posedge ACLK); #1;
        S_AXI_ARVALID = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            t = 0;
            while (!S_AXI_RVALID && t < TMO) begin @(posedge ACLK); #1; t++; end
            if (t >= TMO) timeout("r_valid");
            if (i == 0) rlat = t;
            rbuf[i]  = S_AXI_RDATA;
            rlbuf[i] = S_AXI_RLAST;
            rrbuf[i] = S_AXI_RRESP;
            @(posedge ACLK); #1;
        end
        S_AXI_RREADY = 1'b0;
        chk("arready_back", {31'd0, S_AXI_ARREADY}, 32'd1);
    endtask

    initial begin
        int t;
        ARESETN       = 1'b0;
        S_AXI_AWADDR  = '0;
        S_AXI_AWLEN   = '0;
        S_AXI_AWBURST = '0;
        S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA   = '0;
        S_AXI_WSTRB   = '0;
        S_AXI_WLAST   = 1'b0;
        S_AXI_WVALID  = 1'b0;
        S_AXI_BREADY  = 1'b0;
        S_AXI_ARADDR  = '0;
        S_AXI_ARLEN   = '0;
        S_AXI_ARBURST = '0;
        S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY  = 1'b0;

        repeat (3) @(posedge ACLK);
        #1;
        chk("rst_awready", {31'd0, S_AXI_AWREADY}, 32'd0);
        chk("rst_wready", {31'd0, S_AXI_WREADY}, 32'd0);
        chk("rst_bvalid", {31'd0, S_AXI_BVALID}, 32'd0);
        chk("rst_arready", {31'd0, S_AXI_ARREADY}, 32'd0);
        chk("rst_rvalid", {31'd0, S_AXI_RVALID}, 32'd0);
        chk("rst_rlast", {31'd0, S_AXI_RLAST}, 32'd0);
        chk("rst_rdata", S_AXI_RDATA, 32'h0);
        chk("rst_bresp", {30'd0, S_AXI_BRESP}, 32'd0);
        chk("rst_rresp", {30'd0, S_AXI_RRESP}, 32'd0);
        @(negedge ACLK);
        ARESETN = 1'b1;
        #1;
        chk("awready_pre_edge", {31'd0, S_AXI_AWREADY}, 32'd0);
        @(posedge ACLK); #1;
        chk("awready_post_rst", {31'd0, S_AXI_AWREADY}, 32'd1);
        chk("arready_post_rst", {31'd0, S_AXI_ARREADY}, 32'd1);

        // Single beat write/read
        wbuf[0] = 32'hDEADBEEF;
        axi_write(32'h10, 8'd0, 2'd1, 1, 4'hF, 0, 2'b00);
        axi_read(32'h10, 8'd0, 2'd1);
        chk("single_rdata", rbuf[0], 32'hDEADBEEF);
        chk("single_rlast", {31'd0, rlbuf[0]}, 32'd1);
        chk("single_rresp", {30'd0, rrbuf[0]}, 32'd0);
        chk("read_latency", rlat, 32'd2);

        // INCR burst of four
        wbuf[0] = 32'd1; wbuf[1] = 32'd2; wbuf[2] = 32'd3; wbuf[3] = 32'd4;
        axi_write(32'h100, 8'd3, 2'd1, 4, 4'hF, 0, 2'b00);
        axi_read(32'h100, 8'd3, 2'd1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("incr_rdata%0d", i), rbuf[i], 32'(i + 1));
            chk($sformatf("incr_rlast%0d", i), {31'd0, rlbuf[i]}, (i == 3) ? 32'd1 : 32'd0);
        end

        // Byte strobes
        wbuf[0] = 32'hFFFFFFFF;
        axi_write(32'h200, 8'd0, 2'd1, 1, 4'hF, 0, 2'b00);
        wbuf[0] = 32'h0000AAAA;
        axi_write(32'h200, 8'd0, 2'd1, 1, 4'b0011, 0, 2'b00);
        axi_read(32'h200, 8'd0, 2'd1);
        chk("strb_rdata", rbuf[0], 32'hFFFFAAAA);

        // FIXED burst overwrites the same word
        wbuf[0] = 32'd5; wbuf[1] = 32'd6;
        axi_write(32'h300, 8'd1, 2'd0, 2, 4'hF, 0, 2'b00);
        axi_read(32'h300, 8'd0, 2'd1);
        chk("fixed_rdata", rbuf[0], 32'd6);

        // Backpressured B channel
        wbuf[0] = 32'h12345678;
        axi_write(32'h400, 8'd0, 2'd1, 1, 4'hF, 5, 2'b00);

        // Early WLAST: SLVERR, beats still written
        wbuf[0] = 32'd7; wbuf[1] = 32'd8;
        axi_write(32'h500, 8'd3, 2'd1, 2, 4'hF, 0, 2'b10);
        axi_read(32'h500, 8'd1, 2'd1);
        chk("short_rdata0", rbuf[0], 32'd7);
        chk("short_rdata1", rbuf[1], 32'd8);

        // Overrun: beat past AWLEN dropped, SLVERR
        wbuf[0] = 32'h55;
        axi_write(32'h604, 8'd0, 2'd1, 1, 4'hF, 0, 2'b00);
        wbuf[0] = 32'd9; wbuf[1] = 32'd10;
        axi_write(32'h600, 8'd0, 2'd1, 2, 4'hF, 0, 2'b10);
        axi_read(32'h600, 8'd1, 2'd1);
        chk("over_rdata0", rbuf[0], 32'd9);
        chk("over_rdata1", rbuf[1], 32'h55);

        // WRAP behaves as INCR
        wbuf[0] = 32'hC; wbuf[1] = 32'hD;
        axi_write(32'h700, 8'd1, 2'd2, 2, 4'hF, 0, 2'b00);
        axi_read(32'h704, 8'd0, 2'd2);
        chk("wrap_rdata", rbuf[0], 32'hD);

        // Address wraps at top of memory; upper bits alias
        wbuf[0] = 32'hA1; wbuf[1] = 32'hB2;
        axi_write(32'hFFC, 8'd1, 2'd1, 2, 4'hF, 0, 2'b00);
        axi_read(32'h000, 8'd0, 2'd1);
        chk("wrap0_rdata", rbuf[0], 32'hB2);
        axi_read(32'hFFC, 8'd0, 2'd1);
        chk("top_rdata", rbuf[0], 32'hA1);
        axi_read(32'h1000, 8'd0, 2'd1);
        chk("alias_rdata", rbuf[0], 32'hB2);

        // Reset in the middle of a read burst
        S_AXI_ARADDR  = 32'h100;
        S_AXI_ARLEN   = 8'd3;
        S_AXI_ARBURST = 2'd1;
        S_AXI_ARVALID = 1'b1;
        S_AXI_RREADY  = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_ARVALID = 1'b0;
        t = 0;
        while (!S_AXI_RVALID && t < TMO) begin @(posedge ACLK); #1; t++; end
        if (t >= TMO) timeout("mid_beat0");
        chk("mid_rdata0", S_AXI_RDATA, 32'd1);
        @(posedge ACLK); #1;
        t = 0;
        while (!S_AXI_RVALID && t < TMO) begin @(posedge ACLK); #1; t++; end
        if (t >= TMO) timeout("mid_beat1");
        chk("mid_rdata1", S_AXI_RDATA, 32'd2);
        ARESETN = 1'b0;
        #1;
        chk("mid_rvalid", {31'd0, S_AXI_RVALID}, 32'd0);
        chk("mid_rlast", {31'd0, S_AXI_RLAST}, 32'd0);
        chk("mid_rdata_rst", S_AXI_RDATA, 32'h0);
        chk("mid_arready", {31'd0, S_AXI_ARREADY}, 32'd0);
        S_AXI_RREADY = 1'b0;
        repeat (2) @(posedge ACLK);
        #2;
        ARESETN = 1'b1;
        S_AXI_RREADY = 1'b1;
        @(posedge ACLK); #1;
        chk("rel_arready", {31'd0, S_AXI_ARREADY}, 32'd1);
        chk("rel_awready", {31'd0, S_AXI_AWREADY}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            chk("rel_no_rvalid", {31'd0, S_AXI_RVALID}, 32'd0);
            @(posedge ACLK); #1;
        end
        S_AXI_RREADY = 1'b0;

        // Memory survives reset
        axi_read(32'h10, 8'd0, 2'd1);
        chk("kept_rdata", rbuf[0], 32'hDEADBEEF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
